reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
- Up to N requesters compete to load the register. The block grants one requester at a time, commits that requester's data to the register, and returns a one-cycle acknowledge.
- A requester may lock the grant for a bounded burst.
- It sits in front of the register-update path (q <= data on a clock edge) so that the path has exactly one writer per commit.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 8, register/data width in bits.
- MAX_BURST, 4, maximum consecutive grants to one locked requester before forced rotation (1..15).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester write request; level; held until ack or withdrawn.
- lock  input  N  per-requester burst lock; sampled only in COMMIT.
- data  input  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- gnt  output  N  one-hot grant, registered.
- ack  output  N  one-hot one-cycle commit acknowledge, registered.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  one-cycle pulse when q was written this cycle.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, also mid-operation):
  - state=IDLE; gnt=0, ack=0, q=0, q_valid=0, busy=0.
  - Round-robin pointer ptr=0; burst counter cnt=0.
  - No write or ack completes for an in-flight grant.
- FSM states: IDLE, GRANT, COMMIT.
- Arbitration function (used in IDLE and COMMIT):
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, … modulo N.
  - ptr wraps N-1 -> 0.
- IDLE:
  - If any req: gnt <= onehot(winner), cnt <= 1, -> GRANT.
  - Else stay in IDLE.
- GRANT (gnt[w]=1):
  - If req[w]=1: q <= data[w]; q_valid <= 1; ack <= onehot(w); gnt <= 0; ptr <= (w+1) mod N; -> COMMIT.
  - If req[w]=0 (withdrawn): gnt <= 0; q unchanged; no ack; ptr unchanged; -> IDLE.
  - data is sampled only on this edge; changes at any other time have no effect.
- COMMIT (ack[w]=1, q_valid=1 for exactly this cycle):
  - If lock[w]=1, req[w]=1 and cnt < MAX_BURST: gnt <= onehot(w), cnt <= cnt+1, -> GRANT. ptr is ignored for this re-grant.
  - Else if any req: arbitrate from the updated ptr, gnt <= onehot(winner), cnt <= 1, -> GRANT.
  - Else: -> IDLE.
  - A requester must deassert or keep req after seeing ack. If req is still high, it counts as a new request.
- Latency:
  - req sampled in IDLE at edge k.
  - gnt high after edge k.
  - q, q_valid and ack high after edge k+1.
  - Next gnt after edge k+2.
  - Sustained throughput is one write per 2 cycles.
- Invariants:
  - gnt and ack are never both nonzero.
  - Each of gnt and ack has at most one bit set.
  - q changes only together with q_valid.
- Counter widths:
  - cnt is ceil(log2(MAX_BURST+1)) bits and saturates logically through the cnt < MAX_BURST check.
  - ptr is ceil(log2(N)) bits, with explicit wrap at N.
- With MAX_BURST=1, lock has no effect.

Test Plan:
- Reset: hold rst_n=0 with random req/data -> gnt=0, ack=0, q=0x00, q_valid=0, busy=0. Release; no activity until req.
- Single request: req=4'b0100, data[2]=0x5A from IDLE at cycle 0 -> gnt=4'b0100 at cycle 1; q=0x5A, ack=4'b0100, q_valid=1 at cycle 2; busy=0 at cycle 3 after req dropped.
- Fairness: req=4'b1111 held, lock=0, data[i]=0x10+i -> grant order 0,1,2,3,0, one every 2 cycles; q sequence 0x10,0x11,0x12,0x13,0x10.
- Burst lock: MAX_BURST=4, req=4'b0011 held, lock=4'b0001 -> grants 0,0,0,0,1,0,0,0,0,1; no grant gap between locked writes.
- Withdrawal: req[1] drops in the cycle gnt=4'b0010 -> no q_valid, no ack, q keeps its prior value, state IDLE, next arbitration still starts at the prior ptr.
- Async reset mid-operation: rst_n low during COMMIT (ack=4'b1000) -> ack, q_valid, q and busy clear immediately, not at the next edge; after release with req=4'b1001, the grant goes to requester 0 (ptr=0).

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
//   One requester is granted at a time. Its data is committed to q and a
//   one-cycle ack is returned. A locked requester can hold the grant for up
//   to MAX_BURST back-to-back writes before it is forced to rotate.
//
// Ports
//   clk, rst_n   clock (posedge) / asynchronous active-low reset
//   req[N]       per-requester write request (level)
//   lock[N]      per-requester burst lock, looked at only in COMMIT
//   data[N*W]    requester i data at [i*WIDTH +: WIDTH]
//   gnt[N]       registered one-hot grant
//   ack[N]       registered one-hot commit acknowledge (one cycle)
//   q[W]         shared register
//   q_valid      pulses for the cycle in which q was just written
//   busy         state != IDLE
module reg_write_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       lock,
    input  logic [N*WIDTH-1:0] data,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   q,
    output logic               q_valid,
    output logic               busy
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n;
    logic [PW-1:0]       own, own_n;    // index of the requester currently served
    logic [PW-1:0]       win;
    logic [PW-1:0]       own_next;
    logic [CW-1:0]       cnt, cnt_n;
    logic [N-1:0]        gnt_n, ack_n;
    logic [WIDTH-1:0]    q_n;
    logic                q_valid_n;
    logic                any_req;
    logic                found;
    int                  idx;

    logic [N-1:0][WIDTH-1:0] dvec;
    assign dvec = data;

    assign any_req = |req;
    assign busy    = (state != IDLE);

    // Pointer that follows the served requester, with explicit wrap for
    // non-power-of-two N.
    assign own_next = (own == PW'(N - 1)) ? '0 : own + PW'(1);

    // Round-robin pick: first requester at or after ptr. In COMMIT ptr has
    // already moved past the requester just served.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = '0;
        ack_n     = '0;
        q_n       = q;
        q_valid_n = 1'b0;
        ptr_n     = ptr;
        cnt_n     = cnt;
        own_n     = own;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_n   = N'(1) << win;
                    own_n   = win;
                    cnt_n   = CW'(1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[own]) begin
                    q_n       = dvec[own];
                    q_valid_n = 1'b1;
                    ack_n     = N'(1) << own;
                    ptr_n     = own_next;
                    state_n   = COMMIT;
                end else begin
                    // Withdrawn: drop the grant, leave q and ptr alone.
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                if (lock[own] && req[own] && (cnt < MAX_B)) begin
                    // Burst continuation bypasses the round-robin pointer.
                    gnt_n   = N'(1) << own;
                    cnt_n   = cnt + CW'(1);
                    state_n = GRANT;
                end else if (any_req) begin
                    gnt_n   = N'(1) << win;
                    own_n   = win;
                    cnt_n   = CW'(1);
                    state_n = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
            own     <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            ack     <= ack_n;
            q       <= q_n;
            q_valid <= q_valid_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            own     <= own_n;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter (N=4, WIDTH=8, MAX_BURST=4).
//   Expected commits (ack, q) are queued when stimulus is applied and popped
//   whenever the DUT pulses q_valid.
module tb_reg_write_arbiter;

    localparam int N         = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            req, lock;
    logic [N-1:0][WIDTH-1:0] dv;
    logic [N-1:0]            gnt, ack;
    logic [WIDTH-1:0]        q;
    logic                    q_valid, busy;

    reg_write_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .data(dv),
        .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]     ack;
        logic [WIDTH-1:0] q;
    } wr_t;

    wr_t              sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] prev_q;
    int               ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [WIDTH-1:0] v);
        wr_t e;
        e.ack = N'(1) << i;
        e.q   = v;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, and score writes.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        check("gnt_ack_exclusive", 32'(|gnt && |ack), 0);
        if (q_valid) begin
            if (sb.size() == 0) begin
                check("spurious_write", 32'(q_valid), 0);
            end else begin
                e = sb.pop_front();
                check("sb_ack", 32'(ack), 32'(e.ack));
                check("sb_q", 32'(q), 32'(e.q));
            end
        end else begin
            check("ack_without_qvalid", 32'(ack), 0);
            check("q_stable", 32'(q), 32'(prev_q));
        end
        prev_q = q;
    endtask

    task automatic do_reset();
        req   = '0;
        lock  = '0;
        rst_n = 1'b0;
        #20;
        prev_q = '0;
        check("rst_busy", 32'(busy), 0);
        check("rst_q", 32'(q), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with random inputs applied
        rst_n  = 1'b0;
        req    = N'($urandom);
        lock   = N'($urandom);
        dv     = $urandom;
        prev_q = '0;
        repeat (3) tick();
        check("reset_gnt", 32'(gnt), 0);
        check("reset_ack", 32'(ack), 0);
        check("reset_q", 32'(q), 0);
        check("reset_qvalid", 32'(q_valid), 0);
        check("reset_busy", 32'(busy), 0);
        req   = '0;
        lock  = '0;
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_gnt", 32'(gnt), 0);

        // Single request
        dv[2] = 8'h5A;
        push(2, 8'h5A);
        req = 4'b0100;
        tick();
        check("single_gnt", 32'(gnt), 32'(4'b0100));
        check("single_busy", 32'(busy), 1);
        tick();
        check("single_q", 32'(q), 32'h5A);
        check("single_qvalid", 32'(q_valid), 1);
        check("single_gnt_clear", 32'(gnt), 0);
        req = '0;
        tick();
        check("single_idle", 32'(busy), 0);

        // Fairness: all requesting, no lock
        do_reset();
        for (int i = 0; i < N; i++) dv[i] = WIDTH'(8'h10 + i);
        for (int k = 0; k < 5; k++) push(k % N, WIDTH'(8'h10 + (k % N)));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("fair_gnt", 32'(gnt), 32'(1 << (k % N)));
            tick();
        end
        req = '0;
        tick();
        check("fair_idle", 32'(busy), 0);

        // Burst lock on requester 0
        do_reset();
        dv[0] = 8'hA0;
        dv[1] = 8'hB1;
        for (int k = 0; k < 10; k++) push(ord[k], (ord[k] == 0) ? 8'hA0 : 8'hB1);
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("burst_gnt", 32'(gnt), 32'(1 << ord[k]));
            tick();
        end
        req  = '0;
        lock = '0;
        tick();
        check("burst_idle", 32'(busy), 0);

        // Withdrawal during GRANT
        do_reset();
        dv[0] = 8'h33;
        push(0, 8'h33);
        req = 4'b0001;
        tick();
        tick();
        req = '0;
        tick();
        dv[1] = 8'h77;
        req = 4'b0010;
        tick();
        check("wd_gnt", 32'(gnt), 32'(4'b0010));
        req = '0;
        tick();
        check("wd_ack", 32'(ack), 0);
        check("wd_busy", 32'(busy), 0);
        check("wd_q_kept", 32'(q), 32'h33);
        dv[1] = 8'h78;
        push(1, 8'h78);
        req = 4'b0011;
        tick();
        check("wd_ptr_kept", 32'(gnt), 32'(4'b0010));
        tick();
        req = '0;
        tick();

        // Asynchronous reset while in COMMIT
        do_reset();
        dv[3] = 8'hC3;
        dv[0] = 8'h0D;
        push(3, 8'hC3);
        req = 4'b1000;
        tick();
        check("ar_gnt", 32'(gnt), 32'(4'b1000));
        tick();
        check("ar_ack", 32'(ack), 32'(4'b1000));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ack_clear", 32'(ack), 0);
        check("ar_qvalid_clear", 32'(q_valid), 0);
        check("ar_q_clear", 32'(q), 0);
        check("ar_busy_clear", 32'(busy), 0);
        check("ar_gnt_clear", 32'(gnt), 0);
        prev_q = '0;
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        push(0, 8'h0D);
        tick();
        check("ar_regrant_ptr0", 32'(gnt), 32'(4'b0001));
        tick();
        req = '0;
        tick();
        check("ar_idle", 32'(busy), 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
